// File: rtl/execute_memory_pipe_if.sv
// Signal bundle for execute_memory_pipe: upstream op, external FPU port, downstream result.
// The misalign signal exists only when MISALIGN_TRAP_EN is defined.
interface execute_memory_pipe_if;
  // valid/ready: a transfer happens on a rising edge where valid && ready are both 1;
  // the producer holds valid and its payload until then, and ready never depends on valid.
  logic        in_valid, in_ready;
  logic [31:0] SrcA, WriteData, ImmExt, SrcAF, SrcBF;
  logic        ALUSrc, FPUAinSel, DSrc, MemSrc, MemWrite, MemRead;
  logic [2:0]  ALUControl, funct3;
  logic [4:0]  selFPU;
  logic        fpu_req, fpu_done;
  logic [31:0] fpu_a, fpu_b, fpu_result;
  logic [4:0]  fpu_sel;
  logic        out_valid, out_ready;
  logic [31:0] muxpal_result, ReadData;
  logic        zero, fpu_timeout;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  modport slave (
    input  in_valid, SrcA, WriteData, ImmExt, SrcAF, SrcBF, ALUSrc, ALUControl,
           FPUAinSel, selFPU, DSrc, MemSrc, MemWrite, MemRead, funct3,
           fpu_done, fpu_result, out_ready,
    output in_ready, fpu_req, fpu_a, fpu_b, fpu_sel, out_valid, muxpal_result,
           ReadData, zero, fpu_timeout
`ifdef MISALIGN_TRAP_EN
           , misalign
`endif
  );

  modport master (
    output in_valid, SrcA, WriteData, ImmExt, SrcAF, SrcBF, ALUSrc, ALUControl,
           FPUAinSel, selFPU, DSrc, MemSrc, MemWrite, MemRead, funct3,
           fpu_done, fpu_result, out_ready,
    input  in_ready, fpu_req, fpu_a, fpu_b, fpu_sel, out_valid, muxpal_result,
           ReadData, zero, fpu_timeout
`ifdef MISALIGN_TRAP_EN
           , misalign
`endif
  );
endinterface

// File: rtl/execute_memory_pipe.sv
// Handshaked execute/memory stage: ALU or external multi-cycle FPU op, optional access to an
// internal little-endian data memory, result held until accepted. Option: MISALIGN_TRAP_EN.
module execute_memory_pipe #(
  parameter int MEM_DEPTH   = 64,
  parameter int AW          = $clog2(MEM_DEPTH) + 2,
  parameter int FPU_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  execute_memory_pipe_if.slave  bus,
  output logic [2:0]            dbg_state_o
);
  typedef enum logic [2:0] {IDLE = 3'd0, FPU_WAIT = 3'd1, EXEC = 3'd2, MEM = 3'd3, HOLD = 3'd4} state_t;

  typedef struct packed {
    logic [31:0] src_a, write_data, imm, src_bf;
    logic        alu_src;
    logic [2:0]  alu_ctl;
    logic        dsrc, mem_src, mem_write, mem_read;
    logic [2:0]  funct3;
  } op_t;

  localparam int CW      = (FPU_TIMEOUT > 1) ? $clog2(FPU_TIMEOUT) : 1;
  localparam int TO_LAST = (FPU_TIMEOUT > 0) ? FPU_TIMEOUT - 1 : 0;
  localparam int IW      = AW - 2;

  state_t          state_q, state_d;
  op_t             op_q;
  logic            fpu_req_q, zero_q, to_q;
  logic [31:0]     fpu_a_q, fpu_b_q, fpu_res_q, res_q, rd_q, rdata_q;
  logic [4:0]      fpu_sel_q;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     mem [MEM_DEPTH];

  logic            accept, timeout_hit, misal, do_store, do_read;
  logic [31:0]     alu_b, alu_y, exec_res, st_src, st_data, ld_shift, ld_data;
  logic [1:0]      size, lane, ld_lane;
  logic [3:0]      be;
  logic [IW-1:0]   widx;

  // Half accesses at odd offsets and word accesses at any nonzero offset fall back to the aligned lane.
  function automatic logic [1:0] lane_of(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   lane_of = off;
      2'b01:   lane_of = {off[1], 1'b0};
      default: lane_of = 2'b00;
    endcase
  endfunction

  assign bus.in_ready = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign timeout_hit  = (FPU_TIMEOUT != 0) && (cnt_q == CW'(TO_LAST));

  // ALU encoding: add, sub, and, or, xor, slt, sll, srl.
  always_comb begin
    alu_b = op_q.alu_src ? op_q.imm : op_q.write_data;
    case (op_q.alu_ctl)
      3'b000:  alu_y = op_q.src_a + alu_b;
      3'b001:  alu_y = op_q.src_a - alu_b;
      3'b010:  alu_y = op_q.src_a & alu_b;
      3'b011:  alu_y = op_q.src_a | alu_b;
      3'b100:  alu_y = op_q.src_a ^ alu_b;
      3'b101:  alu_y = {31'd0, $signed(op_q.src_a) < $signed(alu_b)};
      3'b110:  alu_y = op_q.src_a << alu_b[4:0];
      default: alu_y = op_q.src_a >> alu_b[4:0];
    endcase
  end

  assign exec_res = op_q.dsrc ? fpu_res_q : alu_y;
  assign size     = op_q.funct3[1:0];
  assign widx     = exec_res[AW-1:2];
  assign lane     = lane_of(size, exec_res[1:0]);

`ifdef MISALIGN_TRAP_EN
  assign misal = (op_q.mem_read || op_q.mem_write) &&
                 (((size == 2'b01) && exec_res[0]) || (size[1] && (exec_res[1:0] != 2'b00)));
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    st_src = op_q.mem_src ? op_q.src_bf : op_q.write_data;
    case (size)
      2'b00:   begin st_data = {4{st_src[7:0]}};  be = 4'b0001 << lane; end
      2'b01:   begin st_data = {2{st_src[15:0]}}; be = 4'b0011 << lane; end
      default: begin st_data = st_src;            be = 4'b1111;         end
    endcase
  end

  // A store takes priority over a load when both are requested.
  assign do_store = (state_q == EXEC) && op_q.mem_write && !misal;
  assign do_read  = (state_q == EXEC) && op_q.mem_read && !op_q.mem_write && !misal;

  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
    if (do_read) rdata_q <= mem[widx];
  end

  assign ld_lane  = lane_of(size, res_q[1:0]);
  assign ld_shift = rdata_q >> {ld_lane, 3'b000};

  always_comb begin
    case (size)
      2'b00:   ld_data = op_q.funct3[2] ? {24'd0, ld_shift[7:0]}  : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_data = op_q.funct3[2] ? {16'd0, ld_shift[15:0]} : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept) state_d = bus.DSrc ? FPU_WAIT : EXEC;
      FPU_WAIT: if (bus.fpu_done) state_d = EXEC;
                else if (timeout_hit) state_d = HOLD;
      EXEC:     state_d = do_read ? MEM : HOLD;
      MEM:      state_d = HOLD;
      HOLD:     if (bus.out_ready) state_d = accept ? (bus.DSrc ? FPU_WAIT : EXEC) : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      fpu_req_q <= 1'b0;
      fpu_a_q   <= '0;
      fpu_b_q   <= '0;
      fpu_sel_q <= '0;
      fpu_res_q <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      rd_q      <= '0;
      zero_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= '{src_a: bus.SrcA, write_data: bus.WriteData, imm: bus.ImmExt, src_bf: bus.SrcBF,
                   alu_src: bus.ALUSrc, alu_ctl: bus.ALUControl, dsrc: bus.DSrc, mem_src: bus.MemSrc,
                   mem_write: bus.MemWrite, mem_read: bus.MemRead, funct3: bus.funct3};
        cnt_q <= '0;
        if (bus.DSrc) begin
          fpu_req_q <= 1'b1;
          fpu_a_q   <= bus.FPUAinSel ? bus.SrcA : bus.SrcAF;
          fpu_b_q   <= bus.SrcBF;
          fpu_sel_q <= bus.selFPU;
        end
      end
      case (state_q)
        FPU_WAIT: begin
          if (bus.fpu_done) begin
            fpu_res_q <= bus.fpu_result;
            fpu_req_q <= 1'b0;
          end else if (timeout_hit) begin
            fpu_req_q <= 1'b0;
            res_q     <= '0;
            rd_q      <= '0;
            zero_q    <= (alu_y == 32'd0);
            to_q      <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        EXEC: begin
          res_q  <= exec_res;
          zero_q <= (alu_y == 32'd0);
          rd_q   <= '0;
          to_q   <= 1'b0;
        end
        MEM:     rd_q <= ld_data;
        default: ;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                     mis_q <= 1'b0;
    else if (state_q == EXEC)                                       mis_q <= misal;
    else if ((state_q == FPU_WAIT) && !bus.fpu_done && timeout_hit) mis_q <= 1'b0;
  end
  assign bus.misalign = mis_q;
`endif

  assign bus.out_valid     = (state_q == HOLD);
  assign bus.fpu_req       = fpu_req_q;
  assign bus.fpu_a         = fpu_a_q;
  assign bus.fpu_b         = fpu_b_q;
  assign bus.fpu_sel       = fpu_sel_q;
  assign bus.muxpal_result = res_q;
  assign bus.ReadData      = rd_q;
  assign bus.zero          = zero_q;
  assign bus.fpu_timeout   = to_q;
  assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_execute_memory_pipe.sv
// Directed bench for execute_memory_pipe: dut_a uses the default FPU timeout, dut_b uses 4.
// Inputs are shared; sel_b routes in_valid/fpu_done and output observation to one instance.
module tb_execute_memory_pipe;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        sel_b = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1, fpu_done = 1'b0;
  logic [31:0] fpu_result = '0;
  logic [31:0] src_a, write_data, imm_ext, src_af, src_bf;
  logic        alu_src, fpuain_sel, dsrc, mem_src, mem_write, mem_read;
  logic [2:0]  alu_ctl, funct3;
  logic [4:0]  sel_fpu;
  logic [2:0]  dbg_a, dbg_b;
  int          errors = 0;
  int          checks = 0;

  execute_memory_pipe_if bus_a ();
  execute_memory_pipe_if bus_b ();

  assign bus_a.in_valid = in_valid && !sel_b;  assign bus_b.in_valid = in_valid && sel_b;
  assign bus_a.fpu_done = fpu_done && !sel_b;  assign bus_b.fpu_done = fpu_done && sel_b;
  assign bus_a.SrcA = src_a;           assign bus_b.SrcA = src_a;
  assign bus_a.WriteData = write_data; assign bus_b.WriteData = write_data;
  assign bus_a.ImmExt = imm_ext;       assign bus_b.ImmExt = imm_ext;
  assign bus_a.SrcAF = src_af;         assign bus_b.SrcAF = src_af;
  assign bus_a.SrcBF = src_bf;         assign bus_b.SrcBF = src_bf;
  assign bus_a.ALUSrc = alu_src;       assign bus_b.ALUSrc = alu_src;
  assign bus_a.ALUControl = alu_ctl;   assign bus_b.ALUControl = alu_ctl;
  assign bus_a.FPUAinSel = fpuain_sel; assign bus_b.FPUAinSel = fpuain_sel;
  assign bus_a.selFPU = sel_fpu;       assign bus_b.selFPU = sel_fpu;
  assign bus_a.DSrc = dsrc;            assign bus_b.DSrc = dsrc;
  assign bus_a.MemSrc = mem_src;       assign bus_b.MemSrc = mem_src;
  assign bus_a.MemWrite = mem_write;   assign bus_b.MemWrite = mem_write;
  assign bus_a.MemRead = mem_read;     assign bus_b.MemRead = mem_read;
  assign bus_a.funct3 = funct3;        assign bus_b.funct3 = funct3;
  assign bus_a.fpu_result = fpu_result; assign bus_b.fpu_result = fpu_result;
  assign bus_a.out_ready = out_ready;  assign bus_b.out_ready = out_ready;

  execute_memory_pipe dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a), .dbg_state_o(dbg_a));
  execute_memory_pipe #(.FPU_TIMEOUT(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b), .dbg_state_o(dbg_b));

  logic        o_in_ready, o_out_valid, o_zero, o_to, o_fpu_req;
  logic [31:0] o_res, o_rd, o_fpu_a, o_fpu_b;
  logic [4:0]  o_fpu_sel;
  assign o_in_ready  = sel_b ? bus_b.in_ready      : bus_a.in_ready;
  assign o_out_valid = sel_b ? bus_b.out_valid     : bus_a.out_valid;
  assign o_zero      = sel_b ? bus_b.zero          : bus_a.zero;
  assign o_to        = sel_b ? bus_b.fpu_timeout   : bus_a.fpu_timeout;
  assign o_fpu_req   = sel_b ? bus_b.fpu_req       : bus_a.fpu_req;
  assign o_res       = sel_b ? bus_b.muxpal_result : bus_a.muxpal_result;
  assign o_rd        = sel_b ? bus_b.ReadData      : bus_a.ReadData;
  assign o_fpu_a     = sel_b ? bus_b.fpu_a         : bus_a.fpu_a;
  assign o_fpu_b     = sel_b ? bus_b.fpu_b         : bus_a.fpu_b;
  assign o_fpu_sel   = sel_b ? bus_b.fpu_sel       : bus_a.fpu_sel;
`ifdef MISALIGN_TRAP_EN
  logic o_mis;
  assign o_mis = sel_b ? bus_b.misalign : bus_a.misalign;
`endif

  // ---------------- driver tasks ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    src_a = '0; write_data = '0; imm_ext = '0; src_af = '0; src_bf = '0;
    alu_src = 1'b0; fpuain_sel = 1'b0; dsrc = 1'b0; mem_src = 1'b0;
    mem_write = 1'b0; mem_read = 1'b0; alu_ctl = 3'b000; funct3 = 3'b000; sel_fpu = '0;
  endtask

  task automatic issue;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until out_valid is seen; saturates at 20 on a hang.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic alu_op(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] imm,
                        input logic asrc, input logic [2:0] ctl);
    idle_inputs();
    src_a = a; write_data = wd; imm_ext = imm; alu_src = asrc; alu_ctl = ctl;
    issue();
  endtask

  task automatic mem_op(input logic [31:0] addr, input logic [31:0] wd, input logic we, input logic re,
                        input logic [2:0] f3, input logic ms, input logic [31:0] bf);
    idle_inputs();
    src_a = addr; alu_src = 1'b1; write_data = wd; mem_write = we; mem_read = re;
    funct3 = f3; mem_src = ms; src_bf = bf;
    issue();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    step(); step();
    checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", o_in_ready); end
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", o_out_valid); end
    checks++; if (o_fpu_req !== 1'b0) begin errors++; $display("FAIL reset_fpu_req: got %b exp 0", o_fpu_req); end
    checks++; if (o_res !== 32'h0) begin errors++; $display("FAIL reset_result: got %h exp 0", o_res); end
    checks++; if (o_rd !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h exp 0", o_rd); end
    checks++; if ({o_zero, o_to} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b exp 00", {o_zero, o_to}); end
    checks++; if ({dbg_a, dbg_b} !== 6'd0) begin errors++; $display("FAIL reset_state: got %h exp 0", {dbg_a, dbg_b}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_alu;
    int lat;
    alu_op(32'd5, 32'd0, 32'd7, 1'b1, 3'b000);
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL alu_add_early_valid: got %b exp 0", o_out_valid); end
    wait_valid(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL alu_add_latency: got %0d exp 2", lat); end
    checks++; if (o_res !== 32'd12) begin errors++; $display("FAIL alu_add_result: got %h exp %h", o_res, 32'd12); end
    checks++; if (o_zero !== 1'b0) begin errors++; $display("FAIL alu_add_zero: got %b exp 0", o_zero); end
    checks++; if (o_rd !== 32'h0) begin errors++; $display("FAIL alu_add_readdata: got %h exp 0", o_rd); end
    alu_op(32'd5, 32'd5, 32'd99, 1'b0, 3'b001);
    wait_valid(lat);
    checks++; if (o_res !== 32'd0) begin errors++; $display("FAIL alu_sub_result: got %h exp 0", o_res); end
    checks++; if (o_zero !== 1'b1) begin errors++; $display("FAIL alu_sub_zero: got %b exp 1", o_zero); end
    alu_op(32'hFFFF_FFFD, 32'd2, 32'd0, 1'b0, 3'b101);
    wait_valid(lat);
    checks++; if (o_res !== 32'd1) begin errors++; $display("FAIL alu_slt_result: got %h exp 1", o_res); end
    step();
  endtask

  task automatic test_fpu_done_ignored;
    fpu_done = 1'b1; fpu_result = 32'hDEAD_BEEF;
    step();
    fpu_done = 1'b0;
    checks++; if ({o_in_ready, o_out_valid, o_fpu_req} !== 3'b100) begin
      errors++; $display("FAIL stray_done_idle: got %b exp 100", {o_in_ready, o_out_valid, o_fpu_req});
    end
  endtask

  task automatic test_store_load;
    int lat;
    mem_op(32'h10, 32'h0, 1'b1, 1'b0, 3'b010, 1'b0, 32'h0);       // sw 0 @0x10
    wait_valid(lat);
    mem_op(32'h13, 32'h0000_00F0, 1'b1, 1'b0, 3'b000, 1'b0, 32'h0); // sb @0x13
    wait_valid(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sb_latency: got %0d exp 2", lat); end
    checks++; if (o_res !== 32'h13) begin errors++; $display("FAIL sb_address: got %h exp 13", o_res); end
    checks++; if (o_rd !== 32'h0) begin errors++; $display("FAIL sb_readdata: got %h exp 0", o_rd); end
    mem_op(32'h13, 32'h0, 1'b0, 1'b1, 3'b000, 1'b0, 32'h0);         // lb
    wait_valid(lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL lb_latency: got %0d exp 3", lat); end
    checks++; if (o_rd !== 32'hFFFF_FFF0) begin errors++; $display("FAIL lb_sext: got %h exp FFFFFFF0", o_rd); end
    mem_op(32'h13, 32'h0, 1'b0, 1'b1, 3'b100, 1'b0, 32'h0);         // lbu
    wait_valid(lat);
    checks++; if (o_rd !== 32'h0000_00F0) begin errors++; $display("FAIL lbu_zext: got %h exp 000000F0", o_rd); end
    mem_op(32'h10, 32'h0, 1'b0, 1'b1, 3'b010, 1'b0, 32'h0);         // lw
    wait_valid(lat);
    checks++; if (o_rd !== 32'hF000_0000) begin errors++; $display("FAIL lw_after_sb: got %h exp F0000000", o_rd); end
    mem_op(32'h14, 32'h1122_3344, 1'b1, 1'b0, 3'b010, 1'b0, 32'h0); // sw
    wait_valid(lat);
    mem_op(32'h16, 32'h1234_BEEF, 1'b1, 1'b0, 3'b001, 1'b0, 32'h0); // sh upper half
    wait_valid(lat);
    mem_op(32'h14, 32'h0, 1'b0, 1'b1, 3'b010, 1'b0, 32'h0);
    wait_valid(lat);
    checks++; if (o_rd !== 32'hBEEF_3344) begin errors++; $display("FAIL sh_lanes: got %h exp BEEF3344", o_rd); end
    mem_op(32'h16, 32'h0, 1'b0, 1'b1, 3'b001, 1'b0, 32'h0);         // lh
    wait_valid(lat);
    checks++; if (o_rd !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_sext: got %h exp FFFFBEEF", o_rd); end
    mem_op(32'h16, 32'h0, 1'b0, 1'b1, 3'b101, 1'b0, 32'h0);         // lhu
    wait_valid(lat);
    checks++; if (o_rd !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_zext: got %h exp 0000BEEF", o_rd); end
    mem_op(32'h15, 32'h0, 1'b0, 1'b1, 3'b001, 1'b0, 32'h0);         // lh at odd offset
    wait_valid(lat);
    checks++; if (o_rd !== (TRAP ? 32'h0 : 32'h0000_3344)) begin
      errors++; $display("FAIL lh_odd_offset: got %h exp %h", o_rd, (TRAP ? 32'h0 : 32'h0000_3344));
    end
`ifdef MISALIGN_TRAP_EN
    checks++; if (o_mis !== 1'b1) begin errors++; $display("FAIL lh_odd_misalign: got %b exp 1", o_mis); end
`endif
    mem_op(32'h17, 32'h0, 1'b0, 1'b1, 3'b010, 1'b0, 32'h0);         // lw at offset 3
    wait_valid(lat);
    checks++; if (lat !== (TRAP ? 2 : 3)) begin errors++; $display("FAIL lw_off3_latency: got %0d exp %0d", lat, (TRAP ? 2 : 3)); end
    checks++; if (o_rd !== (TRAP ? 32'h0 : 32'hBEEF_3344)) begin
      errors++; $display("FAIL lw_off3_masked: got %h exp %h", o_rd, (TRAP ? 32'h0 : 32'hBEEF_3344));
    end
    mem_op(32'h18, 32'hDEAD_BEEF, 1'b1, 1'b1, 3'b010, 1'b1, 32'hAAAA_5555); // both set, store of SrcBF
    wait_valid(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rw_both_latency: got %0d exp 2", lat); end
    checks++; if (o_rd !== 32'h0) begin errors++; $display("FAIL rw_both_readdata: got %h exp 0", o_rd); end
    mem_op(32'h118, 32'h0, 1'b0, 1'b1, 3'b010, 1'b0, 32'h0);        // wraps to 0x18
    wait_valid(lat);
    checks++; if (o_rd !== 32'hAAAA_5555) begin errors++; $display("FAIL lw_wrap_srcbf: got %h exp AAAA5555", o_rd); end
    step();
  endtask

  task automatic test_fpu;
    int lat, req_cycles;
    idle_inputs();
    dsrc = 1'b1; fpuain_sel = 1'b1; src_a = 32'h3F80_0000; src_af = 32'h1234_5678;
    src_bf = 32'h4000_0000; sel_fpu = 5'd3;
    issue();
    checks++; if (o_fpu_a !== 32'h3F80_0000) begin errors++; $display("FAIL fpu_a_srca: got %h exp 3F800000", o_fpu_a); end
    checks++; if ({o_fpu_b, o_fpu_sel} !== {32'h4000_0000, 5'd3}) begin
      errors++; $display("FAIL fpu_b_sel: got %h/%0d exp 40000000/3", o_fpu_b, o_fpu_sel);
    end
    src_a = 32'h0; src_bf = 32'h0; sel_fpu = 5'd0;
    req_cycles = 0;
    repeat (4) begin
      if (o_fpu_req && !o_out_valid) req_cycles++;
      step();
    end
    checks++; if (req_cycles !== 4 || o_fpu_req !== 1'b1) begin
      errors++; $display("FAIL fpu_req_held: got %0d/%b exp 4/1", req_cycles, o_fpu_req);
    end
    checks++; if (o_fpu_a !== 32'h3F80_0000) begin errors++; $display("FAIL fpu_a_stable: got %h exp 3F800000", o_fpu_a); end
    fpu_done = 1'b1; fpu_result = 32'h4040_0000;
    step();
    fpu_done = 1'b0; fpu_result = 32'h0;
    checks++; if (o_fpu_req !== 1'b0) begin errors++; $display("FAIL fpu_req_drop: got %b exp 0", o_fpu_req); end
    wait_valid(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL fpu_latency: got %0d exp 2", lat); end
    checks++; if (o_res !== 32'h4040_0000) begin errors++; $display("FAIL fpu_result: got %h exp 40400000", o_res); end
    checks++; if (o_to !== 1'b0) begin errors++; $display("FAIL fpu_no_timeout: got %b exp 0", o_to); end
    step();
  endtask

  task automatic test_timeout;
    int lat, req_cycles;
    sel_b = 1'b1;
    step();
    mem_op(32'h0, 32'h5A5A_5A5A, 1'b1, 1'b0, 3'b010, 1'b0, 32'h0);
    wait_valid(lat);
    idle_inputs();
    dsrc = 1'b1; mem_write = 1'b1; write_data = 32'hFFFF_FFFF; funct3 = 3'b010;
    issue();
    req_cycles = 0;
    while (o_fpu_req && req_cycles < 20) begin
      req_cycles++;
      step();
    end
    checks++; if (req_cycles !== 4) begin errors++; $display("FAIL timeout_req_cycles: got %0d exp 4", req_cycles); end
    checks++; if ({o_out_valid, o_to} !== 2'b11) begin errors++; $display("FAIL timeout_flag: got %b exp 11", {o_out_valid, o_to}); end
    checks++; if ({o_res, o_rd} !== 64'h0) begin errors++; $display("FAIL timeout_result: got %h/%h exp 0/0", o_res, o_rd); end
    step();
    mem_op(32'h0, 32'h0, 1'b0, 1'b1, 3'b010, 1'b0, 32'h0);
    wait_valid(lat);
    checks++; if (o_rd !== 32'h5A5A_5A5A) begin errors++; $display("FAIL timeout_mem_kept: got %h exp 5A5A5A5A", o_rd); end
    checks++; if (o_to !== 1'b0) begin errors++; $display("FAIL timeout_cleared: got %b exp 0", o_to); end
    step();
    sel_b = 1'b0;
    step();
  endtask

  task automatic test_back_to_back;
    int lat;
    out_ready = 1'b0;
    alu_op(32'h0100, 32'h0023, 32'h0, 1'b0, 3'b011);
    wait_valid(lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL bp_latency: got %0d exp 2", lat); end
    repeat (3) begin
      step();
      checks++; if ({o_out_valid, o_in_ready, o_res} !== {2'b10, 32'h123}) begin
        errors++; $display("FAIL bp_hold: got %b%b/%h exp 10/00000123", o_out_valid, o_in_ready, o_res);
      end
    end
    idle_inputs();
    src_a = 32'hF0F0; write_data = 32'hFF00; alu_ctl = 3'b010;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (o_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b exp 1", o_in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL bp_same_cycle_accept: got %b exp 0", o_out_valid); end
    wait_valid(lat);
    checks++; if (lat !== 2 || o_res !== 32'hF000) begin
      errors++; $display("FAIL bp_next_op: got %0d/%h exp 2/0000F000", lat, o_res);
    end
    step();
  endtask

  task automatic test_reset_mid_fpu;
    int lat;
    idle_inputs();
    dsrc = 1'b1; src_af = 32'h1;
    issue();
    step(); step();
    checks++; if (o_fpu_req !== 1'b1) begin errors++; $display("FAIL mid_fpu_req: got %b exp 1", o_fpu_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({o_fpu_req, o_in_ready, o_out_valid} !== 3'b010) begin
      errors++; $display("FAIL async_reset: got %b exp 010", {o_fpu_req, o_in_ready, o_out_valid});
    end
    #1 rst_n = 1'b1;
    step();
    alu_op(32'd10, 32'd3, 32'd0, 1'b0, 3'b001);
    wait_valid(lat);
    checks++; if (lat !== 2 || o_res !== 32'd7) begin
      errors++; $display("FAIL after_reset_op: got %0d/%h exp 2/00000007", lat, o_res);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_fpu_done_ignored();
    test_store_load();
    test_fpu();
    test_timeout();
    test_back_to_back();
    test_reset_mid_fpu();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/execute_memory_pipe.md
Name: execute_memory_pipe

Overview:
- Handshaked, parametrised successor of the single-cycle execute/memory stage.
- Accepts one operation per transaction:
  - integer ALU op, or
  - multi-cycle FPU op through an external FPU request/done port.
- Optionally performs a data-memory access on an internal little-endian memory of MEM_DEPTH words.
- Holds the result until the downstream stage accepts it; sits between the decode/register-read stage and writeback.

Parameters:
- MEM_DEPTH, 64: data memory depth in 32-bit words; power of two, >= 4.
- AW, $clog2(MEM_DEPTH)+2: byte-address width used from the result.
- FPU_TIMEOUT, 255: max cycles waiting for fpu_done before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation present
- in_ready  out  1  stage can accept operation
- SrcA  in  32  integer operand A
- WriteData  in  32  integer operand B / store data
- ImmExt  in  32  immediate
- SrcAF  in  32  FP operand A
- SrcBF  in  32  FP operand B / FP store data
- ALUSrc  in  1  0: B=WriteData, 1: B=ImmExt
- ALUControl  in  3  existing ALU encoding
- FPUAinSel  in  1  0: FPU A=SrcAF, 1: FPU A=SrcA
- selFPU  in  5  FPU operation select
- DSrc  in  1  0: ALU result, 1: FPU result
- MemSrc  in  1  store data: 0 WriteData, 1 SrcBF
- MemWrite  in  1  store
- MemRead  in  1  load
- funct3  in  3  [1:0] size 00 byte / 01 half / 10 word; [2]=1 zero-extend, 0 sign-extend
- fpu_req  out  1  FPU request, level until fpu_done
- fpu_a, fpu_b  out  32  FPU operands (registered)
- fpu_sel  out  5  FPU op (registered)
- fpu_done  in  1  FPU result valid (single-cycle pulse)
- fpu_result  in  32  FPU result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- muxpal_result  out  32  ALU/FPU result (also the memory address)
- ReadData  out  32  load data, extended; 0 if not a load
- zero  out  1  ALU zero flag of the accepted op
- fpu_timeout  out  1  result aborted by timeout

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except in_ready=1; memory contents are not reset.
- Accept: in_valid && in_ready. All inputs are captured into the operation register; no input is sampled afterwards.
- FSM:
  - IDLE: in_ready=1. On accept:
    - DSrc=0 -> EXEC.
    - DSrc=1 -> FPU_WAIT, with fpu_req=1 and fpu_a/fpu_b/fpu_sel loaded.
  - FPU_WAIT: fpu_req held high.
    - On fpu_done: latch fpu_result, fpu_req=0 -> EXEC.
    - If counter reaches FPU_TIMEOUT (>0): fpu_req=0, result=0, fpu_timeout=1, memory access suppressed -> HOLD.
  - EXEC:
    - Result = ALU or latched FPU result.
    - Store: write memory this cycle -> HOLD.
    - Load: issue synchronous read -> MEM.
    - Otherwise -> HOLD.
  - MEM: capture read word, apply size/extension -> HOLD.
  - HOLD: out_valid=1. When out_ready=1: if in_valid=1, accept the next op in the same cycle (in_ready=out_ready in HOLD); otherwise -> IDLE.
- Latency, accept to out_valid:
  - ALU or store: 2 cycles.
  - ALU load: 3 cycles.
  - FPU: fpu_done cycle + 2 (+1 for load).
- Outputs are stable while out_valid=1 && out_ready=0.
- Memory map:
  - Word index = result[AW-1:2]; upper bits ignored (wrap modulo MEM_DEPTH*4).
  - Byte lane = result[1:0].
  - Store byte/half writes only the addressed lanes.
  - Half at offset 1 or 3 and word at offset != 0 use the aligned address: low bits masked.
- MemRead && MemWrite both set: store wins, ReadData=0.
- fpu_done while not in FPU_WAIT: ignored.
- Reset mid-operation: FSM returns to IDLE, fpu_req drops immediately, a pending store is lost.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Misaligned half/word access suppresses the write and the read.
  - Returns ReadData=0 and asserts output misalign (1 bit, valid with out_valid).
- Undefined: no misalign port; low-bit masking as above.

Test Plan:
- Reset, ALU add: SrcA=5, ImmExt=7, ALUSrc=1, ALUControl=add -> out_valid 2 cycles after accept, muxpal_result=12, zero=0, ReadData=0.
- Store then load: sb of 0x000000F0 at addr 0x13, then lb at 0x13 -> ReadData=0xFFFFFFF0. lbu -> 0x000000F0. lw at 0x10 -> 0xF0000000 if prior word was 0.
- FPU op: DSrc=1, FPUAinSel=1, fpu_done after 5 cycles with 0x40400000 -> fpu_a=SrcA, fpu_req high exactly until done, muxpal_result=0x40400000 two cycles later.
- FPU_TIMEOUT=4, fpu_done never arrives -> fpu_req drops after 4 cycles, out_valid with fpu_timeout=1, result 0, memory unchanged.
- Backpressure: out_ready=0 for 3 cycles -> outputs constant, in_ready=0. Then out_ready=1 with in_valid=1 -> next op accepted in the same cycle.
- Reset asserted during FPU_WAIT -> fpu_req=0 and in_ready=1 asynchronously; a later op completes normally.
